// File: rtl/bram_pkg.sv
// Shared types and defaults for the bram_manager request side:
// matrix payload type, bank encoding, sequencer states and the
// default completion timeout.
package bram_pkg;

    localparam int DEF_ROWS    = 16;
    localparam int DEF_COLS    = 128;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 1024;

    typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][DEF_DW-1:0] mat_t;

    typedef enum logic [1:0] {
        BANK_Q = 2'b00,
        BANK_K = 2'b01,
        BANK_V = 2'b10,
        BANK_O = 2'b11
    } bank_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_WAIT_WR,
        ST_RESP
    } state_e;

    // Bank field of a select byte ([7:6]); the low six bits are the tile index.
    function automatic bank_e sel_bank(input logic [7:0] sel);
        return bank_e'(sel[7:6]);
    endfunction

endpackage

// File: rtl/bram_req_timer.sv
// Completion watchdog for the request sequencer: an up-counter that can be
// cleared or loaded, and flags when it sits on its terminal count
// (TIMEOUT-1).
module bram_req_timer #(
    parameter int TIMEOUT = 1024,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_CLR,
    input  logic          I_EN,
    input  logic          I_LOAD,
    input  logic [CW-1:0] I_LOAD_VAL,
    output logic          O_TC
);

    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Clear has priority over load, load over counting.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_count <= '0;
        end else if (I_CLR) begin
            r_count <= '0;
        end else if (I_LOAD) begin
            r_count <= I_LOAD_VAL;
        end else if (I_EN) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign O_TC = (r_count == TC_VAL);

endmodule

// File: rtl/bram_req_master.sv
// Initiator-side sequencer for bram_manager. Takes one read/write command
// at a time, fires a single-cycle request pulse, waits for the matching
// completion (or a timeout), then holds a response until it is accepted.
module bram_req_master
    import bram_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                             I_CLK,
    input  logic                             I_RST_N,
    input  logic                             I_CMD_VLD,
    output logic                             O_CMD_RDY,
    input  logic                             I_CMD_WR,
    input  logic [7:0]                       I_CMD_SEL,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0] I_CMD_MAT,
    output logic                             O_RD_VLD_PULSE,
    output logic                             O_WR_VLD_PULSE,
    output logic [7:0]                       O_SEL,
    output logic [ROWS-1:0][COLS-1:0][DW-1:0] O_MAT,
    input  logic                             I_VLD,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0] I_MAT,
    input  logic                             I_WR_DONE,
    output logic                             O_RSP_VLD,
    input  logic                             I_RSP_RDY,
    output logic                             O_RSP_WR,
    output logic [7:0]                       O_RSP_SEL,
    output logic [ROWS-1:0][COLS-1:0][DW-1:0] O_RSP_MAT,
    output logic                             O_RSP_ERR
);

    localparam int CW = $clog2(TIMEOUT);

    state_e r_state;
    state_e w_state_next;

    logic                              r_wr;
    logic [7:0]                        r_sel;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] r_mat;
    logic                              r_rd_pulse;
    logic                              r_wr_pulse;
    logic                              r_rsp_wr;
    logic [7:0]                        r_rsp_sel;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] r_rsp_mat;
    logic                              r_rsp_err;

    logic w_accept;
    logic w_waiting;
    logic w_tc;
    logic w_rd_done;
    logic w_wr_done;
    logic w_timeout;
    logic w_enter_rsp;

    // Completions only count in the wait state of the matching type, so
    // stray or wrong-type strobes elsewhere fall through untouched.
    assign w_accept    = (r_state == ST_IDLE) && I_CMD_VLD;
    assign w_waiting   = (r_state == ST_WAIT_RD) || (r_state == ST_WAIT_WR);
    assign w_rd_done   = (r_state == ST_WAIT_RD) && I_VLD;
    assign w_wr_done   = (r_state == ST_WAIT_WR) && I_WR_DONE;
    assign w_timeout   = w_waiting && w_tc && !w_rd_done && !w_wr_done;
    assign w_enter_rsp = w_rd_done || w_wr_done || w_timeout;

    bram_req_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timer (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .I_CLR      (r_state == ST_ISSUE),
        .I_EN       (w_waiting),
        .I_LOAD     (1'b0),
        .I_LOAD_VAL ('0),
        .O_TC       (w_tc)
    );

    // State register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; ISSUE always lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (I_CMD_VLD) w_state_next = ST_ISSUE;
            ST_ISSUE:   w_state_next = r_wr ? ST_WAIT_WR : ST_WAIT_RD;
            ST_WAIT_RD: if (w_enter_rsp) w_state_next = ST_RESP;
            ST_WAIT_WR: if (w_enter_rsp) w_state_next = ST_RESP;
            ST_RESP:    if (I_RSP_RDY) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Command capture and request pulses; the pulse is registered off the
    // accept so it lines up with the ISSUE cycle.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_wr       <= 1'b0;
            r_sel      <= '0;
            r_mat      <= '0;
            r_rd_pulse <= 1'b0;
            r_wr_pulse <= 1'b0;
        end else begin
            r_rd_pulse <= w_accept && !I_CMD_WR;
            r_wr_pulse <= w_accept && I_CMD_WR;
            if (w_accept) begin
                r_wr  <= I_CMD_WR;
                r_sel <= I_CMD_SEL;
                r_mat <= I_CMD_WR ? I_CMD_MAT : '0;
            end
        end
    end

    // Response capture on the way into RESP; held there until accepted.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_rsp_wr  <= 1'b0;
            r_rsp_sel <= '0;
            r_rsp_mat <= '0;
            r_rsp_err <= 1'b0;
        end else if (w_enter_rsp) begin
            r_rsp_wr  <= r_wr;
            r_rsp_sel <= r_sel;
            r_rsp_mat <= w_rd_done ? I_MAT : '0;
            r_rsp_err <= w_timeout;
        end
    end

    // Ready is gated by reset so it reads low while reset is held.
    assign O_CMD_RDY      = (r_state == ST_IDLE) && I_RST_N;
    assign O_RD_VLD_PULSE = r_rd_pulse;
    assign O_WR_VLD_PULSE = r_wr_pulse;
    assign O_SEL          = r_sel;
    assign O_MAT          = r_mat;
    assign O_RSP_VLD      = (r_state == ST_RESP);
    assign O_RSP_WR       = r_rsp_wr;
    assign O_RSP_SEL      = r_rsp_sel;
    assign O_RSP_MAT      = r_rsp_mat;
    assign O_RSP_ERR      = r_rsp_err;

endmodule

// File: doc/bram_req_master.md
Name: bram_req_master

Overview:
- Initiator-side sequencer for bram_manager.
- Accepts read/write commands from the attention datapath over valid/ready, and drives bram_manager's one-cycle RD/WR pulses, SEL and matrix bus.
- Waits for bram_manager's completion (O_VLD / O_WR_DONE), with a timeout guard.
- Returns read matrices or write acknowledgements upstream over a held valid/ready response channel.

Parameters:
- ROWS, 16, matrix rows.
- COLS, 128, matrix columns.
- DW, 8, element width in bits.
- TIMEOUT, 1024, max cycles to wait for completion before error; must be ≥ 2.

Ports:
- I_CLK  in  1  clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_CMD_VLD  in  1  command valid.
- O_CMD_RDY  out  1  command ready.
- I_CMD_WR  in  1  1 = write, 0 = read.
- I_CMD_SEL  in  8  [7:6] bank (Q/K/V/O), [5:0] tile index.
- I_CMD_MAT  in  DW × [ROWS][COLS]  write data.
- O_RD_VLD_PULSE  out  1  read request pulse to bram_manager.
- O_WR_VLD_PULSE  out  1  write request pulse to bram_manager.
- O_SEL  out  8  select to bram_manager.
- O_MAT  out  DW × [ROWS][COLS]  write data to bram_manager.
- I_VLD  in  1  bram_manager read data valid.
- I_MAT  in  DW × [ROWS][COLS]  bram_manager read data.
- I_WR_DONE  in  1  bram_manager write complete.
- O_RSP_VLD  out  1  response valid.
- I_RSP_RDY  in  1  response ready.
- O_RSP_WR  out  1  response is for a write.
- O_RSP_SEL  out  8  select of the completed command.
- O_RSP_MAT  out  DW × [ROWS][COLS]  read data; zero for writes and errors.
- O_RSP_ERR  out  1  timeout occurred.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0; O_CMD_RDY = 0 during reset, 1 in the first cycle after release.
  - All matrices cleared; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- IDLE:
  - O_CMD_RDY = 1.
  - On I_CMD_VLD at a clock edge: register WR, SEL and MAT (MAT only for writes; zero it for reads) → ISSUE.
- ISSUE (exactly one cycle):
  - Assert O_RD_VLD_PULSE or O_WR_VLD_PULSE according to the registered WR.
  - O_SEL / O_MAT carry the registered values and stay stable until the state returns to IDLE.
  - Next state WAIT_RD or WAIT_WR; counter cleared.
- Pulses are registered outputs, high for exactly one cycle, never both high.
- Command accepted at edge N → pulse high during cycle N+1.
- WAIT_RD:
  - First edge with I_VLD = 1: capture I_MAT into the response register → RESP with ERR = 0.
  - Completion in the same cycle as the pulse is not possible; I_VLD is only sampled from the cycle after ISSUE.
- WAIT_WR: first edge with I_WR_DONE = 1 → RESP with ERR = 0, MAT = 0.
- Timeout:
  - The counter increments each cycle in WAIT_*.
  - When counter == TIMEOUT-1 and no completion is seen: → RESP with ERR = 1, MAT = 0.
  - Completion and the terminal count in the same cycle: completion wins, ERR = 0.
- RESP:
  - O_RSP_VLD = 1; WR, SEL, MAT and ERR held stable until I_RSP_RDY is sampled high.
  - On acceptance → IDLE. O_CMD_RDY is low throughout RESP; no command overlap.
  - Command-to-command throughput is at least 4 cycles.
- Stray I_VLD / I_WR_DONE in IDLE, ISSUE or RESP are ignored.
- Wrong-type completion is ignored: I_WR_DONE in WAIT_RD, I_VLD in WAIT_WR.
- A completion arriving after a timeout is ignored.
- Reset asserted mid-transaction aborts immediately to reset values; no response is produced.

Decomposition:
- Package bram_pkg:
  - typedef mat_t (DW-bit [ROWS][COLS]).
  - enum bank_e {BANK_Q = 2'b00, BANK_K = 2'b01, BANK_V = 2'b10, BANK_O = 2'b11}.
  - FSM state enum.
  - Default TIMEOUT constant.
- Sub-module bram_req_timer: loadable up-counter with clear and terminal-count flag, instantiated once.

Test Plan:
- Read: cmd RD, SEL = 8'h40 (bank K, idx 0); model returns I_MAT all 8'h66 with I_VLD 3 cycles after the pulse → one-cycle O_RD_VLD_PULSE with O_SEL = 8'h40; O_RSP_VLD with O_RSP_MAT all 8'h66, ERR = 0, WR = 0.
- Write: cmd WR, SEL = 8'hC0, MAT rows cycling 8'h55/66/77/88; model asserts I_WR_DONE 5 cycles later → O_WR_VLD_PULSE single cycle, O_MAT matches the command; response WR = 1, MAT = 0, ERR = 0. A follow-up read of 8'hC0 returns the same rows.
- Backpressure: hold I_RSP_RDY = 0 for 10 cycles → O_RSP_VLD and data stable, O_CMD_RDY = 0; release → IDLE next cycle.
- Timeout: TIMEOUT = 8, no completion → O_RSP_VLD 8 cycles after ISSUE with ERR = 1. A late I_VLD is ignored.
- Priority: I_VLD exactly on the terminal-count cycle → ERR = 0 and data captured. Stray I_VLD in IDLE → no response.
- Reset in WAIT_WR: assert I_RST_N = 0 → all outputs 0 asynchronously. After release O_CMD_RDY = 1 and no response is emitted.
